// File: rtl/fsm_11001_det.sv
// Serial sequence detector for the pattern 1-1-0-0-1 with overlap.
// Mealy output: y is high combinationally while the FSM holds the
// "1100" prefix and the current input bit is 1.
//
//   state | meaning
//   ------+------------------------------------------
//   S0    | idle, no useful prefix seen
//   S1    | prefix "1"
//   S2    | prefix "11"
//   S3    | prefix "110"
//   S4    | prefix "1100", a 1 now completes the match
//   other | unused encoding, returns to S0 next edge
module fsm_11001_det (
    input  logic din,
    input  logic clk,
    input  logic rst,
    output logic y
);

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;

    logic [2:0] state_q;
    logic [2:0] state_d;

    // State register with synchronous reset back to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; each transition keeps the longest suffix that is
    // still a prefix of the pattern, so overlapping matches are found.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0: state_d = din ? S1 : S0;
            S1: state_d = din ? S2 : S0;
            S2: state_d = din ? S2 : S3;
            S3: state_d = din ? S1 : S4;
            S4: state_d = din ? S1 : S0;
            default: state_d = S0;
        endcase
    end

    // Detect output; din only matters once the full "1100" prefix is held,
    // so an unknown input in earlier states cannot raise y.
    always_comb begin
        y = 1'b0;
        if (!rst && (state_q == S4)) begin
            y = din;
        end
    end

endmodule

// File: tb/tb_fsm_11001_det.sv
// Self-checking bench for fsm_11001_det: a vector table of
// {rst, din, expected y} applied one bit per cycle, plus a hand-written
// sequence exercising the combinational Mealy path inside one cycle.
module tb_fsm_11001_det;

    typedef struct {
        logic rst;
        logic din;
        logic exp_y;
        string tag;
    } vec_t;

    logic din;
    logic clk;
    logic rst;
    logic y;

    vec_t vecs[$];
    logic exp_q[$];
    string tag_q[$];
    int checks;
    int errors;

    fsm_11001_det dut (
        .din (din),
        .clk (clk),
        .rst (rst),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic d, input logic e, input string t);
        vec_t v;
        v.rst = r;
        v.din = d;
        v.exp_y = e;
        v.tag = t;
        vecs.push_back(v);
    endtask

    task automatic add_seq(input string bits, input string exp, input string t);
        for (int i = 0; i < bits.len(); i++) begin
            add(1'b0, bits[i] == "1", exp[i] == "1", $sformatf("%s[%0d]", t, i + 1));
        end
    endtask

    task automatic expect_y(input logic e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic compare_y();
        logic e;
        string t;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: y=%b required an expected entry", y);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (y !== e) begin
                errors++;
                $display("FAIL %s: y=%b required %b", t, y, e);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        din = 1'b0;

        // Reset held over several edges with din toggling.
        add(1'b1, 1'b1, 1'b0, "reset_a");
        add(1'b1, 1'b0, 1'b0, "reset_b");
        add(1'b1, 1'b1, 1'b0, "reset_c");
        // Basic detect, then 1,0,0,1 proves the state landed in S1.
        add_seq("11001", "00001", "basic");
        add_seq("1001", "0001", "after_detect");
        add(1'b1, 1'b0, 1'b0, "reset_d");
        // Overlapping stream: hits on bits 6, 10 and 16.
        add_seq("0110011001011001", "0000010001000001", "overlap");
        add(1'b1, 1'b0, 1'b0, "reset_e");
        add_seq("111001", "000001", "near_111001");
        add(1'b1, 1'b0, 1'b0, "reset_f");
        add_seq("1101001", "0000000", "near_1101001");
        add(1'b1, 1'b0, 1'b0, "reset_g");
        add_seq("110001", "000000", "near_110001");
        add(1'b1, 1'b0, 1'b0, "reset_h");
        // Mid-pattern reset: reach S4, reset with din=1 (y must stay low).
        add_seq("1100", "0000", "mid_pre");
        add(1'b1, 1'b1, 1'b0, "mid_rst");
        add(1'b0, 1'b1, 1'b0, "mid_post");
        add_seq("11001", "00001", "mid_fresh");
        add(1'b1, 1'b0, 1'b0, "reset_i");

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst = vecs[i].rst;
            din = vecs[i].din;
            expect_y(vecs[i].exp_y, vecs[i].tag);
            @(negedge clk);
            compare_y();
        end

        // Mealy timing: sit in S4 and toggle din within one cycle.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            din = (i < 2) ? 1'b1 : 1'b0;
            expect_y(1'b0, $sformatf("mealy_pre[%0d]", i + 1));
            @(negedge clk);
            compare_y();
        end
        @(posedge clk);
        #1;
        din = 1'b0;
        expect_y(1'b0, "mealy_s4_din0");
        #1;
        compare_y();
        din = 1'b1;
        expect_y(1'b1, "mealy_s4_din1");
        #1;
        compare_y();
        din = 1'b0;
        expect_y(1'b0, "mealy_s4_din0_again");
        #1;
        compare_y();
        // din=0 at the edge leaves S4 for S0, so a 1 now must not detect.
        @(posedge clk);
        #1;
        din = 1'b1;
        expect_y(1'b0, "mealy_after_edge");
        @(negedge clk);
        compare_y();

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
